// File: rtl/sq_cbrt_sum_pkg.sv
// Shared definitions for the a^2 + cbrt(b) combiner: default width, state encoding
// and result width helper.
package sq_cbrt_sum_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SQ        = 2'd1,
        WAIT_CBRT = 2'd2,
        ADD       = 2'd3
    } state_t;

    function automatic int res_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/sq_cbrt_sum.sv
// y = a^2 + cbrt(b): launches the external cube-root unit on b while squaring a with
// an iterative shift-add, then adds the root to the square through the same adder.
module sq_cbrt_sum
    import sq_cbrt_sum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            a_in,
    input  logic [WIDTH-1:0]            b_in,
    output logic                        cbrt_start,
    output logic [WIDTH-1:0]            cbrt_x,
    input  logic                        cbrt_busy,
    input  logic [WIDTH-1:0]            cbrt_y,
    output logic [res_width(WIDTH)-1:0] y_out,
    output logic                        busy_o
);

    localparam int RW = res_width(WIDTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [RW-1:0]    acc_q;
    logic [RW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] root_q;

    logic [RW-1:0]    add_b_d;
    logic [RW-1:0]    sum_d;

    // The one adder: multiplicand while squaring, zero-extended root for the final sum.
    always_comb begin
        add_b_d = {{WIDTH{1'b0}}, root_q};
        if (state_q == SQ) begin
            add_b_d = mcand_q;
        end
        sum_d = acc_q + add_b_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            root_q     <= '0;
            cbrt_start <= 1'b0;
            cbrt_x     <= '0;
            y_out      <= '0;
            busy_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cbrt_x     <= b_in;
                        cbrt_start <= 1'b1;
                        busy_o     <= 1'b1;
                        acc_q      <= '0;
                        mcand_q    <= {{WIDTH{1'b0}}, a_in};
                        mplier_q   <= a_in;
                        cnt_q      <= '0;
                        state_q    <= SQ;
                    end
                end
                SQ: begin
                    cbrt_start <= 1'b0;
                    if (mplier_q[0]) begin
                        acc_q <= sum_d;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= WAIT_CBRT;
                    end
                end
                WAIT_CBRT: begin
                    // Safe to look at busy now: the squaring phase outlasts its late rise.
                    if (!cbrt_busy) begin
                        root_q  <= cbrt_y;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    y_out   <= sum_d;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sq_cbrt_sum.md
Name: sq_cbrt_sum

Overview:
- Top-level combiner for variant 1, y = a^2 + cbrt(b). Sits directly downstream of the cube-root unit: launches it on b, consumes its 8-bit root, and adds the root to a^2.
- a^2 comes from an internal iterative shift-add squarer. One shared 16-bit adder serves both the squarer accumulation and the final sum, which meets the one-summation budget.
- Block-level start/busy_o handshake, matching the existing arithmetic units.

Parameters:
- WIDTH, 8, operand width of a_in/b_in. Squaring takes WIDTH cycles. Must be >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle request; sampled only in IDLE
- a_in  input  WIDTH  operand to square
- b_in  input  WIDTH  operand for cube root
- cbrt_start  output  1  one-cycle launch pulse to the cube-root unit
- cbrt_x  output  WIDTH  cube-root operand, held stable until the next launch
- cbrt_busy  input  1  cube-root unit busy
- cbrt_y  input  WIDTH  cube-root result, valid when cbrt_busy is low after a launch
- y_out  output  2*WIDTH  result, held until the next completed operation
- busy_o  output  1  high from the cycle after accepted start until the result is written

Behaviour:
- Reset: y_out=0, busy_o=0, cbrt_start=0, cbrt_x=0; internal a/b/acc/mcand/mplier/cnt/root = 0; state=IDLE. Reset is honoured in every state. Mid-operation it aborts with no result written; the cube-root unit shares rst.
- States: IDLE, SQ, WAIT_CBRT, ADD.
- IDLE, start=1 at edge T:
  - capture a_in, b_in
  - cbrt_x<=b_in, cbrt_start<=1, busy_o<=1
  - acc<=0, mcand<={0,a_in}, mplier<=a_in, cnt<=0
  - go to SQ
- IDLE, start=0: hold.
- start outside IDLE is ignored; no second launch.
- SQ, edges T+1..T+WIDTH:
  - cbrt_start<=0, so the launch pulse is exactly one cycle
  - if mplier[0]=1: acc<=acc+mcand
  - mcand<<=1, mplier>>=1, cnt<=cnt+1
  - on cnt==WIDTH-1, go to WAIT_CBRT
- WAIT_CBRT:
  - cbrt_busy is first examined WIDTH+1 cycles after launch. WIDTH>=2 guarantees the unit's one-cycle-late busy rise is never missed.
  - if cbrt_busy=0: root<=cbrt_y, go to ADD; else stay.
  - No timeout: a stuck-busy unit hangs the block, recoverable only by rst.
- ADD: y_out<=acc+{0,root} through the shared adder; busy_o<=0; go to IDLE.
- Latency: minimum WIDTH+2 cycles, start edge to y_out/busy_o update (10 for WIDTH=8). Otherwise bounded by the cube-root completion time plus 1.
- Width rules:
  - acc, mcand and adder are 2*WIDTH bits.
  - Max result 255^2+6=65031 fits in 16 bits; no overflow and no truncation for WIDTH=8.
  - Root zero-extended before the add.
- Start in the same cycle that busy_o falls (the ADD edge) is ignored. It is accepted the following cycle.
- a_in/b_in may change after the start edge without effect.

Decomposition:
- Shared package: WIDTH default, state encoding localparams (IDLE=0, SQ=1, WAIT_CBRT=2, ADD=3), result width 2*WIDTH.
- No sub-module. The squarer is inline because it shares the single adder with the final sum, so splitting it out would duplicate the adder.
- The cube-root unit is a sibling at the top level, wired to the cbrt_* ports, not instantiated here.

Test Plan:
- Bench stub for cube-root: busy rises one cycle after cbrt_start and falls after D cycles; returns a programmed root.
1. a=3, b=27, stub D=40, root 3 -> y_out=12; exactly one cbrt_start pulse with cbrt_x=27; busy_o high until D+2 cycles after launch.
2. a=255, b=216, root 6 -> y_out=65031; no overflow.
3. a=0, b=0, stub D=3, root 0 -> y_out=0; busy_o high exactly 10 cycles (minimum-latency path; WAIT_CBRT exits on first examination).
4. Second start pulse 5 cycles into an operation (a=2, b=8, root 2) -> ignored; one cbrt_start total; y_out=6.
5. rst asserted during SQ (cycle T+4) of a=9, b=64 -> y_out=0, busy_o=0, cbrt_start=0 next edge. Then a=9, b=64 with root 4 -> y_out=85.
6. Integration with the real cube-root unit: a=10, b=8 -> y_out=102; then a=1, b=125 -> y_out=6 with no rst in between.
